reg_xfer_ctrl: RTL

REG_XFER_CTRL -- requirements
Module: reg_xfer_ctrl

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/reg_xfer_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the register-transfer controller: widths, op codes
// and FSM state encodings.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int IDX_W  = 3;

    typedef enum logic [1:0] {
        OP_MOVE  = 2'b00,
        OP_LOADI = 2'b01,
        OP_SWAP  = 2'b10,
        OP_READ  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_WR_A = 3'd3,
        S_WR_B = 3'd4,
        S_DONE = 3'd5
    } state_t;

endpackage

// File: rtl/reg_xfer_ctrl.sv
// Register-bank transfer controller: MOVE / LOADI / SWAP / READ over a shared bus.
// Define REG_XFER_SWAP_EN to build the two-temporary SWAP path; otherwise SWAP is a no-op.
module reg_xfer_ctrl
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [IDX_W-1:0]  cmd_src,
    input  logic [IDX_W-1:0]  cmd_dst,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [IDX_W-1:0]  reg_no,
    output logic              ld_reg,
    output logic              t_reg,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic [DATA_W-1:0] rd_data,
    output logic              done
);

    state_t              state_q, state_d;
    op_t                 op_q, op_d;
    logic [IDX_W-1:0]    src_q, src_d;
    logic [IDX_W-1:0]    dst_q, dst_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic [DATA_W-1:0]   tmp_a_q, tmp_a_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
`ifdef REG_XFER_SWAP_EN
    logic [DATA_W-1:0]   tmp_b_q, tmp_b_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= OP_MOVE;
            src_q     <= '0;
            dst_q     <= '0;
            imm_q     <= '0;
            tmp_a_q   <= '0;
            rd_data_q <= '0;
`ifdef REG_XFER_SWAP_EN
            tmp_b_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            imm_q     <= imm_d;
            tmp_a_q   <= tmp_a_d;
            rd_data_q <= rd_data_d;
`ifdef REG_XFER_SWAP_EN
            tmp_b_q   <= tmp_b_d;
`endif
        end
    end

    // Strobes are decoded from state only, so an async reset clears them at once.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        src_d     = src_q;
        dst_d     = dst_q;
        imm_d     = imm_q;
        tmp_a_d   = tmp_a_q;
        rd_data_d = rd_data_q;
`ifdef REG_XFER_SWAP_EN
        tmp_b_d   = tmp_b_q;
`endif
        cmd_ready = 1'b0;
        reg_no    = '0;
        ld_reg    = 1'b0;
        t_reg     = 1'b0;
        bus_out   = '0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d  = op_t'(cmd_op);
                    src_d = cmd_src;
                    dst_d = cmd_dst;
                    imm_d = cmd_imm;
                    case (op_t'(cmd_op))
                        OP_LOADI: state_d = S_WR_A;
`ifdef REG_XFER_SWAP_EN
                        OP_SWAP:  state_d = S_RD_A;
`else
                        OP_SWAP:  state_d = S_DONE;
`endif
                        default:  state_d = S_RD_A;
                    endcase
                end
            end
            S_RD_A: begin
                reg_no  = src_q;
                t_reg   = 1'b1;
                tmp_a_d = bus_in;
                if (op_q == OP_READ) rd_data_d = bus_in;
                case (op_q)
                    OP_MOVE: state_d = S_WR_A;
`ifdef REG_XFER_SWAP_EN
                    OP_SWAP: state_d = S_RD_B;
`endif
                    default: state_d = S_DONE;
                endcase
            end
`ifdef REG_XFER_SWAP_EN
            S_RD_B: begin
                reg_no  = dst_q;
                t_reg   = 1'b1;
                tmp_b_d = bus_in;
                state_d = S_WR_A;
            end
`endif
            S_WR_A: begin
                reg_no  = dst_q;
                ld_reg  = 1'b1;
                bus_out = (op_q == OP_LOADI) ? imm_q : tmp_a_q;
`ifdef REG_XFER_SWAP_EN
                state_d = (op_q == OP_SWAP) ? S_WR_B : S_DONE;
`else
                state_d = S_DONE;
`endif
            end
`ifdef REG_XFER_SWAP_EN
            S_WR_B: begin
                reg_no  = src_q;
                ld_reg  = 1'b1;
                bus_out = tmp_b_q;
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rd_data = rd_data_q;

endmodule
